// File: rtl/regfile_wb_queue_pkg.sv
// Shared register-file geometry and the write-back entry type.
package regfile_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 8;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer, drain and bypass signals of the write-back queue.
interface regfile_wb_queue_if
    import regfile_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW,
    parameter int CW = 3
);

    logic          alu_valid_i;
    logic          alu_ready_o;
    logic [AW-1:0] alu_addr_i;
    logic [DW-1:0] alu_data_i;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic [AW-1:0] ld_addr_i;
    logic [DW-1:0] ld_data_i;
    logic          wr_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [AW-1:0] rs_addr_i;
    logic          rs_hit_o;
    logic [DW-1:0] rs_data_o;
    logic [AW-1:0] rt_addr_i;
    logic          rt_hit_o;
    logic [DW-1:0] rt_data_o;
    logic [CW-1:0] count_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  ld_valid_i, ld_addr_i, ld_data_i,
        input  rs_addr_i, rt_addr_i,
        output alu_ready_o, ld_ready_o,
        output wr_o, wr_addr_o, wr_data_o,
        output rs_hit_o, rs_data_o, rt_hit_o, rt_data_o,
        output count_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output ld_valid_i, ld_addr_i, ld_data_i,
        output rs_addr_i, rt_addr_i,
        input  alu_ready_o, ld_ready_o,
        input  wr_o, wr_addr_o, wr_data_o,
        input  rs_hit_o, rs_data_o, rt_hit_o, rt_data_o,
        input  count_o
    );

endinterface

// File: rtl/regfile_wb_queue_bypass.sv
// Age-ordered search of the pending write-back entries; the youngest match wins.
module wb_bypass_match #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 3,
    parameter  int DW    = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    i_addr [DEPTH],
    input  logic [DW-1:0]    i_data [DEPTH],
    input  logic [DEPTH-1:0] i_valid,
    input  logic [PW-1:0]    i_tail,
    input  logic [AW-1:0]    i_lookup,
    output logic             o_hit,
    output logic [DW-1:0]    o_data
);

    // Walk oldest to youngest (tail-DEPTH .. tail-1) so later matches override.
    always_comb begin
        logic [PW-1:0] w_idx;
        // NOTE: combinational logic uses blocking '=' and assigns every output before any condition, so no latch is inferred.
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PW'(k);
            if (i_valid[w_idx] && (i_addr[w_idx] == i_lookup)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO merging ALU and load results onto one register-file write port.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    regfile_wb_queue_if.slave   wbq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = CW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic [FW-1:0]    w_free;
    logic             w_acc_alu;
    logic             w_acc_ld;
    logic [PW-1:0]    w_ld_slot;
    logic [DEPTH-1:0] w_valid;

    // The head drains every cycle, so its slot counts as free for this cycle's enqueues.
    assign w_pop  = (r_count != '0);
    assign w_free = FW'(DEPTH) - FW'(r_count) + FW'(w_pop);

    assign wbq.alu_ready_o = reset_ni && (w_free >= FW'(1));
    assign wbq.ld_ready_o  = reset_ni && (w_free >= (wbq.alu_valid_i ? FW'(2) : FW'(1)));

    assign w_acc_alu = wbq.alu_valid_i && wbq.alu_ready_o;
    assign w_acc_ld  = wbq.ld_valid_i && wbq.ld_ready_o;
    assign w_ld_slot = r_tail + PW'(w_acc_alu);

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, PW'(i) - r_head} < r_count);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            // NOTE: entry storage is reset too, so a post-reset bypass or drain can never expose stale data.
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
            if (w_acc_alu) begin
                r_addr[r_tail] <= wbq.alu_addr_i;
                r_data[r_tail] <= wbq.alu_data_i;
            end
            if (w_acc_ld) begin
                r_addr[w_ld_slot] <= wbq.ld_addr_i;
                r_data[w_ld_slot] <= wbq.ld_data_i;
            end
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_acc_alu) + PW'(w_acc_ld);
            r_count <= r_count + CW'(w_acc_alu) + CW'(w_acc_ld) - CW'(w_pop);
        end
    end

    assign wbq.wr_o      = w_pop;
    assign wbq.wr_addr_o = w_pop ? r_addr[r_head] : '0;
    assign wbq.wr_data_o = w_pop ? r_data[r_head] : '0;
    assign wbq.count_o   = r_count;

    wb_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_bypass_s (
        .i_addr   (r_addr),
        .i_data   (r_data),
        .i_valid  (w_valid),
        .i_tail   (r_tail),
        .i_lookup (wbq.rs_addr_i),
        .o_hit    (wbq.rs_hit_o),
        .o_data   (wbq.rs_data_o)
    );

    wb_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_bypass_t (
        .i_addr   (r_addr),
        .i_data   (r_data),
        .i_valid  (w_valid),
        .i_tail   (r_tail),
        .i_lookup (wbq.rt_addr_i),
        .o_hit    (wbq.rt_hit_o),
        .o_data   (wbq.rt_data_o)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: queue-based reference model, separate write monitor.
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = REG_AW;
    localparam int DW    = REG_DW;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    regfile_wb_queue_if #(.AW(AW), .DW(DW), .CW(CW)) wbq ();

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .wbq      (wbq)
    );

    int total = 0;
    int bad   = 0;

    wb_entry_t pend[$];  // entries the model believes are still queued
    wb_entry_t sb[$];    // expected register-file writes, oldest first

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_bypass(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].addr == a) begin
                hit = 1'b1;
                d   = pend[i].data;
                break;
            end
        end
    endfunction

    task automatic cycle(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        int n, free;
        bit ar, lr;
        logic h;
        logic [DW-1:0] d;
        @(negedge clk_i);
        wbq.alu_valid_i = av; wbq.alu_addr_i = aa; wbq.alu_data_i = ad;
        wbq.ld_valid_i  = lv; wbq.ld_addr_i  = la; wbq.ld_data_i  = ldd;
        wbq.rs_addr_i   = rs; wbq.rt_addr_i  = rt;
        #1;
        n    = pend.size();
        free = DEPTH - n + ((n != 0) ? 1 : 0);
        ar   = (free >= 1);
        lr   = (free >= (av ? 2 : 1));
        check("count", 32'(wbq.count_o), 32'(n));
        check("alu_ready", 32'(wbq.alu_ready_o), 32'(ar));
        check("ld_ready", 32'(wbq.ld_ready_o), 32'(lr));
        model_bypass(rs, h, d);
        check("rs_hit", 32'(wbq.rs_hit_o), 32'(h));
        check("rs_data", 32'(wbq.rs_data_o), 32'(d));
        model_bypass(rt, h, d);
        check("rt_hit", 32'(wbq.rt_hit_o), 32'(h));
        check("rt_data", 32'(wbq.rt_data_o), 32'(d));
        @(posedge clk_i);
        if (n != 0) void'(pend.pop_front());
        if (av && ar) begin
            pend.push_back('{addr: aa, data: ad});
            sb.push_back('{addr: aa, data: ad});
        end
        if (lv && lr) begin
            pend.push_back('{addr: la, data: ldd});
            sb.push_back('{addr: la, data: ldd});
        end
    endtask

    task automatic idle(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, rs, rt);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && pend.size() != 0; k++) idle(AW'($urandom), AW'($urandom));
        idle(AW'($urandom), AW'($urandom));
    endtask

    task automatic check_reset_outputs();
        check("rst_wr", 32'(wbq.wr_o), 32'd0);
        check("rst_alu_ready", 32'(wbq.alu_ready_o), 32'd0);
        check("rst_ld_ready", 32'(wbq.ld_ready_o), 32'd0);
        check("rst_rs", {23'd0, wbq.rs_hit_o, wbq.rs_data_o}, 32'd0);
        check("rst_rt", {23'd0, wbq.rt_hit_o, wbq.rt_data_o}, 32'd0);
        check("rst_count", 32'(wbq.count_o), 32'd0);
    endtask

    // Write monitor: every drained entry must match the oldest expected write.
    initial begin
        wb_entry_t e;
        forever begin
            @(posedge clk_i);
            #1;
            check("wr_valid", 32'(wbq.wr_o), 32'(sb.size() != 0));
            if (wbq.wr_o && sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(wbq.wr_addr_o), 32'(e.addr));
                check("wr_data", 32'(wbq.wr_data_o), 32'(e.data));
            end else if (!wbq.wr_o) begin
                check("idle_bus", {21'd0, wbq.wr_addr_o, wbq.wr_data_o}, 32'd0);
            end
        end
    end

    initial begin
        wbq.alu_valid_i = 1'b1; wbq.alu_addr_i = '0; wbq.alu_data_i = '0;
        wbq.ld_valid_i  = 1'b1; wbq.ld_addr_i  = '0; wbq.ld_data_i  = '0;
        wbq.rs_addr_i   = '0;   wbq.rt_addr_i  = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_outputs();
        wbq.alu_valid_i = 1'b0;
        wbq.ld_valid_i  = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;

        // single ALU write
        cycle(1'b1, 3'd3, 8'h5A, 1'b0, '0, '0, 3'd3, 3'd0);
        idle(3'd3, 3'd4);
        idle(3'd3, 3'd3);

        // simultaneous producers to the same register
        cycle(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 3'd2, 3'd2);
        idle(3'd2, 3'd1);
        drain();

        // fill and backpressure
        for (int i = 0; i < 8; i++)
            cycle(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom), DW'($urandom), AW'(i), AW'(i + 1));
        drain();

        // bypass miss and hit, including the cycle the entry sits on the write port
        cycle(1'b1, 3'd1, 8'h10, 1'b1, 3'd2, 8'h20, 3'd5, 3'd6);
        cycle(1'b1, 3'd5, 8'hA0, 1'b0, '0, '0, 3'd5, 3'd6);
        for (int i = 0; i < 4; i++) idle(3'd6, 3'd5);
        drain();

        // wrap-around
        for (int i = 0; i < 10; i++)
            cycle(1'b1, AW'(i), DW'(i), 1'b0, '0, '0, AW'(i), AW'(i + 7));
        drain();

        // address 0 and random traffic
        cycle(1'b1, 3'd0, 8'h77, 1'b1, 3'd0, 8'h78, 3'd0, 3'd0);
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                  AW'($urandom), AW'($urandom));
        drain();

        // reset mid-burst with three entries pending
        cycle(1'b1, 3'd4, 8'hC1, 1'b1, 3'd5, 8'hC2, 3'd4, 3'd5);
        cycle(1'b1, 3'd6, 8'hC3, 1'b1, 3'd7, 8'hC4, 3'd5, 3'd6);
        @(negedge clk_i);
        wbq.alu_valid_i = 1'b1;
        wbq.ld_valid_i  = 1'b1;
        wbq.rs_addr_i   = 3'd6;
        wbq.rt_addr_i   = 3'd5;
        #1;
        check("pre_reset_count", 32'(wbq.count_o), 32'(pend.size()));
        check("pre_reset_rs_hit", 32'(wbq.rs_hit_o), 32'd1);
        reset_ni = 1'b0;
        #1;
        check_reset_outputs();
        pend.delete();
        sb.delete();
        wbq.alu_valid_i = 1'b0;
        wbq.ld_valid_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        idle(3'd6, 3'd5);
        idle(3'd4, 3'd7);
        cycle(1'b1, 3'd1, 8'hE5, 1'b0, '0, '0, 3'd1, 3'd6);
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue sitting in front of the 8×8 register file's single write port. It collects results from two producers, the ALU and the load unit, and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file write port. Two bypass lookup ports let the operand-read stage see values still pending in the queue, which closes the gap between result production and register commit.

## Interface
Parameters:
- DEPTH, 4 — queue entries; power of two, ≥2
- AW, 3 — register address width
- DW, 8 — register data width

Ports:
- clk_i  in  1  clock; all state on rising edge
- reset_ni  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  queue can accept ALU result this cycle
- alu_addr_i  in  AW  ALU destination register
- alu_data_i  in  DW  ALU result
- ld_valid_i  in  1  load result valid
- ld_ready_o  out  1  queue can accept load result this cycle
- ld_addr_i  in  AW  load destination register
- ld_data_i  in  DW  load data
- wr_o  out  1  register file write enable
- wr_addr_o  out  AW  register file write address
- wr_data_o  out  DW  register file write data
- rs_addr_i  in  AW  bypass lookup address, port S
- rs_hit_o  out  1  pending entry matches rs_addr_i
- rs_data_o  out  DW  youngest matching pending data
- rt_addr_i  in  AW  bypass lookup address, port T
- rt_hit_o  out  1  pending entry matches rt_addr_i
- rt_data_o  out  DW  youngest matching pending data
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular FIFO with head/tail pointers and an occupancy count. Each entry holds {addr, data}.
- Drain:
  - wr_o = (count≠0), wr_addr_o/wr_data_o = head entry.
  - The register file always accepts, so the head pops on every edge where wr_o=1.
  - When empty: wr_o=0, wr_addr_o=0, wr_data_o=0.
- Free slots this cycle: free = DEPTH − count + (count≠0 ? 1 : 0). This counts the slot released by the same-cycle pop.
- Ready rules:
  - alu_ready_o = free≥1.
  - ld_ready_o = free ≥ (alu_valid_i ? 2 : 1). This is a combinational dependency on alu_valid_i.
- Accept/enqueue:
  - ALU accepted when alu_valid_i & alu_ready_o; load accepted when ld_valid_i & ld_ready_o.
  - Same-cycle double enqueue: ALU entry is written first (older), load entry second.
- Program order between producers is by acceptance cycle; within one cycle the ALU entry is older.
- Bypass, per port independently:
  - Searches all occupied entries, including the head being written this cycle; the youngest match wins.
  - hit=0 and data=0 when no match.
  - Values being enqueued in the same cycle are not visible until the next cycle.
- Address 0 gets no special treatment: it is queued, written and bypassed like any other address.
- Count arithmetic: count_next = count + accepted_alu + accepted_ld − pop. It never exceeds DEPTH and never goes below 0. Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - count=0, head=tail=0, entry storage cleared to 0.
  - While reset_ni=0: wr_o=0, alu_ready_o=0, ld_ready_o=0, rs/rt_hit_o=0, rs/rt_data_o=0, count_o=0.
- Latency: a result accepted at edge N into an empty queue drives wr_o=1 during cycle N+1 and commits at edge N+1. Worst-case latency is DEPTH cycles.
- Throughput: sustained 1 write/cycle. Bursts of 2/cycle are absorbed until full.
- Full (count=DEPTH):
  - free=1 because of the pop, so alu_ready_o=1.
  - ld_ready_o=1 only when alu_valid_i=0.
- Reset mid-operation discards all pending entries. No partial write is issued after reset assertion.

## Structure
- Package regfile_pkg:
  - localparams REG_AW=3, REG_DW=8.
  - typedef wb_entry_t {logic [REG_AW-1:0] addr; logic [REG_DW-1:0] data}.
- Sub-module wb_bypass_match, instantiated twice (S and T):
  - Inputs: entry array, per-entry valid vector, tail pointer, lookup address.
  - Performs the age-ordered priority search and returns hit and data.
- Top level holds the pointers, count, ready logic and drain.

## Test plan
- Single ALU write: alu_valid_i=1, addr=3, data=0x5A into empty queue → next cycle wr_o=1, wr_addr_o=3, wr_data_o=0x5A; count_o returns to 0.
- Simultaneous producers: ALU (2,0x11) and load (2,0x22) in the same cycle → writes to r2 issue in the order 0x11 then 0x22. rs_addr_i=2 in the cycle after acceptance gives rs_hit_o=1, rs_data_o=0x22.
- Fill and backpressure: both producers valid every cycle with DEPTH=4 → count saturates at 4. ld_ready_o deasserts while alu_valid_i=1, alu_ready_o stays 1, and no entry is lost or duplicated (scoreboard check).
- Bypass miss/hit: queue holds (5,0xA0); rt_addr_i=6 → rt_hit_o=0, rt_data_o=0. rt_addr_i=5 → hit=1, data=0xA0 including the cycle it is on wr_o.
- Wrap-around: 10 single enqueues with values 0..9 → pointers wrap twice and writes emerge in order 0..9.
- Reset mid-burst: assert reset_ni=0 with count=3 → wr_o, ready and hit outputs drop to 0 immediately. After release count_o=0 and no stale write appears.
